// File: rtl/fpu_pkg.sv
// Shared FPU types: IEEE-754 single field widths, packed fp32 view,
// and the state encoding of the integer-to-float converter.
package fpu_pkg;

    localparam int EXP_BIAS = 127;
    localparam int EXP_W    = 8;
    localparam int MAN_W    = 23;

    localparam logic [31:0] FP_POS_ZERO = 32'h0000_0000;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } fp32_t;

    typedef enum logic [2:0] {
        IDLE,
        ABS,
        NORM,
        ROUND,
        DONE
    } itof_state_t;

endpackage

// File: rtl/itof_round.sv
// Combinational rounding stage for int_to_float: packs a normalised
// magnitude (mag[31]=1) into fp32 and reports lost precision.
// Ports: mag/exp/sign in; result (fp32_t) and inexact out.
// ITOF_RNE_EN defined: round-to-nearest-even; undefined: truncation.
module itof_round
    import fpu_pkg::*;
(
    input  logic [31:0]      mag,
    input  logic [EXP_W-1:0] exp,
    input  logic             sign,
    output fp32_t            result,
    output logic             inexact
);

    logic             guard;
    logic             sticky;
    logic [MAN_W-1:0] man;
    logic [MAN_W-1:0] man_r;
    logic [EXP_W-1:0] exp_r;
    logic             unused_bits;

    assign guard   = mag[7];
    assign sticky  = |mag[6:0];
    assign man     = mag[30:8];
    assign inexact = guard | sticky;

`ifdef ITOF_RNE_EN
    logic inc;
    logic carry;

    // Tie (g=1, s=0) rounds up only when the kept LSB is odd.
    assign inc            = guard & (sticky | mag[8]);
    assign {carry, man_r} = {1'b0, man} + {{MAN_W{1'b0}}, inc};
    // All-ones mantissa rolling over bumps the exponent; man_r is 0 then.
    assign exp_r          = exp + {{(EXP_W-1){1'b0}}, carry};
`else
    assign man_r = man;
    assign exp_r = exp;
`endif

    // mag[31] is the implicit leading one; mag[8] only matters for RNE.
    assign unused_bits = ^{mag[31], mag[8]};

    always_comb begin
        result      = '0;
        result.sign = sign;
        result.exp  = exp_r;
        result.man  = man_r;
    end

endmodule

// File: rtl/int_to_float.sv
// Iterative 32-bit integer to IEEE-754 single converter, one request at
// a time. Ports: in_valid/in_ready/int_in request side; out_valid/
// out_ready/fp_out/inexact result side. Optional macro ITOF_RNE_EN
// selects round-to-nearest-even (else truncation). NORM_STEP: 1,2,4,8.
module int_to_float
    import fpu_pkg::*;
#(
    parameter int SIGNED_IN = 1,
    parameter int NORM_STEP = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] int_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] fp_out,
    output logic        inexact
);

    itof_state_t      state_q, state_d;
    logic [31:0]      mag_q, mag_d;
    logic [EXP_W-1:0] exp_q, exp_d;
    logic             sign_q, sign_d;
    logic [31:0]      fp_out_q, fp_out_d;
    logic             inexact_q, inexact_d;

    fp32_t            rnd_res;
    logic             rnd_inexact;

    itof_round u_round (
        .mag     (mag_q),
        .exp     (exp_q),
        .sign    (sign_q),
        .result  (rnd_res),
        .inexact (rnd_inexact)
    );

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign fp_out    = fp_out_q;
    assign inexact   = inexact_q;

    always_comb begin
        state_d   = state_q;
        mag_d     = mag_q;
        exp_d     = exp_q;
        sign_d    = sign_q;
        fp_out_d  = fp_out_q;
        inexact_d = inexact_q;
        unique case (state_q)
            IDLE: begin
                // Raw operand parks in mag until ABS takes its magnitude.
                if (in_valid) begin
                    mag_d   = int_in;
                    state_d = ABS;
                end
            end
            ABS: begin
                sign_d = (SIGNED_IN != 0) && mag_q[31];
                // Unsigned negate: 0x80000000 stays 2^31.
                mag_d  = sign_d ? (~mag_q + 32'd1) : mag_q;
                if (mag_q == 32'd0) begin
                    fp_out_d  = FP_POS_ZERO;
                    inexact_d = 1'b0;
                    state_d   = DONE;
                end else begin
                    exp_d   = EXP_W'(EXP_BIAS + 31);
                    state_d = NORM;
                end
            end
            NORM: begin
                if (mag_q[31]) begin
                    state_d = ROUND;
                end else if (mag_q[31 -: NORM_STEP] == '0) begin
                    mag_d = mag_q << NORM_STEP;
                    exp_d = exp_q - EXP_W'(NORM_STEP);
                end else begin
                    mag_d = mag_q << 1;
                    exp_d = exp_q - EXP_W'(1);
                end
            end
            ROUND: begin
                fp_out_d  = rnd_res;
                inexact_d = rnd_inexact;
                state_d   = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mag_q     <= '0;
            exp_q     <= '0;
            sign_q    <= 1'b0;
            fp_out_q  <= FP_POS_ZERO;
            inexact_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mag_q     <= mag_d;
            exp_q     <= exp_d;
            sign_q    <= sign_d;
            fp_out_q  <= fp_out_d;
            inexact_q <= inexact_d;
        end
    end

endmodule
